// File: rtl/proc_mem_responder.sv
// Memory-side responder for 4-byte read/write/init requests against a local word array.
// The array is accessed at the accept edge; in-order responses leave after a fixed latency.
module proc_mem_responder #(
    parameter int p_num_words = 256,
    parameter int p_latency   = 1,
    parameter int p_qdepth    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    input  logic [2:0]  reqstream_msg_type,
    input  logic [7:0]  reqstream_msg_opaque,
    input  logic [31:0] reqstream_msg_addr,
    input  logic [1:0]  reqstream_msg_len,
    input  logic [31:0] reqstream_msg_data,
    output logic        respstream_val,
    input  logic        respstream_rdy,
    output logic [2:0]  respstream_msg_type,
    output logic [7:0]  respstream_msg_opaque,
    output logic [1:0]  respstream_msg_test,
    output logic [1:0]  respstream_msg_len,
    output logic [31:0] respstream_msg_data
);

    localparam int c_idx_w = $clog2(p_num_words);
    localparam int c_ptr_w = (p_qdepth > 1) ? $clog2(p_qdepth) : 1;
    localparam int c_occ_w = $clog2(p_qdepth + 1);
    localparam int c_lat_w = 3;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(p_qdepth - 1);
    localparam logic [c_occ_w-1:0] c_occ_full = c_occ_w'(p_qdepth);
    localparam logic [c_lat_w-1:0] c_lat_load = c_lat_w'(p_latency - 1);

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_last) ? {c_ptr_w{1'b0}} : ptr + {{(c_ptr_w-1){1'b0}}, 1'b1};
    endfunction

    logic [31:0]        r_mem [p_num_words];
    logic [2:0]         r_q_type   [p_qdepth];
    logic [7:0]         r_q_opaque [p_qdepth];
    logic [1:0]         r_q_test   [p_qdepth];
    logic [1:0]         r_q_len    [p_qdepth];
    logic [31:0]        r_q_data   [p_qdepth];
    logic [c_lat_w-1:0] r_q_cnt    [p_qdepth];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_occ_w-1:0] r_occ;
    logic               r_req_rdy;

    logic [c_idx_w-1:0] w_idx;
    logic               w_bad;
    logic               w_oor;
    logic [1:0]         w_test;
    logic [31:0]        w_rd_data;
    logic               w_fire;
    logic               w_wr_en;
    logic               w_resp_val;
    logic               w_deq;
    logic [c_occ_w-1:0] w_occ_next;
    logic               w_unused_addr;

    assign w_idx         = reqstream_msg_addr[c_idx_w+1:2];
    assign w_unused_addr = ^reqstream_msg_addr[1:0];
    assign w_fire        = reqstream_val & r_req_rdy;
    assign w_resp_val    = (r_occ != {c_occ_w{1'b0}}) && (r_q_cnt[r_head] == {c_lat_w{1'b0}});
    assign w_deq         = w_resp_val & respstream_rdy;
    assign w_wr_en       = w_fire && (w_test == 2'd0) &&
                           ((reqstream_msg_type == 3'd1) || (reqstream_msg_type == 3'd2));

    // Request decode: bad len/type outranks out-of-range; read data only for legal reads.
    always_comb begin
        w_bad     = (reqstream_msg_len != 2'd0) || (reqstream_msg_type > 3'd2);
        w_oor     = |reqstream_msg_addr[31:c_idx_w+2];
        w_test    = 2'd0;
        w_rd_data = 32'd0;
        if (w_bad) begin
            w_test = 2'd2;
        end else if (w_oor) begin
            w_test = 2'd1;
        end else begin
            w_test = 2'd0;
        end
        if ((w_test == 2'd0) && (reqstream_msg_type == 3'd0)) begin
            w_rd_data = r_mem[w_idx];
        end else begin
            w_rd_data = 32'd0;
        end
    end

    // Occupancy update from enqueue/dequeue pair.
    always_comb begin
        w_occ_next = r_occ;
        case ({w_fire, w_deq})
            2'b10:   w_occ_next = r_occ + {{(c_occ_w-1){1'b0}}, 1'b1};
            2'b01:   w_occ_next = r_occ - {{(c_occ_w-1){1'b0}}, 1'b1};
            default: w_occ_next = r_occ;
        endcase
    end

    // Response queue, pointers and request-ready register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head    <= {c_ptr_w{1'b0}};
            r_tail    <= {c_ptr_w{1'b0}};
            r_occ     <= {c_occ_w{1'b0}};
            r_req_rdy <= 1'b0;
            for (int i = 0; i < p_qdepth; i++) begin
                r_q_type[i]   <= 3'd0;
                r_q_opaque[i] <= 8'd0;
                r_q_test[i]   <= 2'd0;
                r_q_len[i]    <= 2'd0;
                r_q_data[i]   <= 32'd0;
                r_q_cnt[i]    <= {c_lat_w{1'b0}};
            end
        end else begin
            r_occ     <= w_occ_next;
            // Ready follows the post-edge occupancy, so a dequeue frees a slot only next cycle.
            r_req_rdy <= (w_occ_next < c_occ_full);
            if (w_deq) begin
                r_head <= f_ptr_inc(r_head);
            end
            if (w_fire) begin
                r_tail <= f_ptr_inc(r_tail);
            end
            for (int i = 0; i < p_qdepth; i++) begin
                if (w_fire && (r_tail == c_ptr_w'(i))) begin
                    r_q_type[i]   <= reqstream_msg_type;
                    r_q_opaque[i] <= reqstream_msg_opaque;
                    r_q_test[i]   <= w_test;
                    r_q_len[i]    <= reqstream_msg_len;
                    r_q_data[i]   <= w_rd_data;
                    r_q_cnt[i]    <= c_lat_load;
                end else if (r_q_cnt[i] != {c_lat_w{1'b0}}) begin
                    r_q_cnt[i] <= r_q_cnt[i] - {{(c_lat_w-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Word array: cleared by reset, written at the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < p_num_words; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_wr_en) begin
            r_mem[w_idx] <= reqstream_msg_data;
        end
    end

    assign reqstream_rdy         = r_req_rdy;
    assign respstream_val        = w_resp_val;
    assign respstream_msg_type   = r_q_type[r_head];
    assign respstream_msg_opaque = r_q_opaque[r_head];
    assign respstream_msg_test   = r_q_test[r_head];
    assign respstream_msg_len    = r_q_len[r_head];
    assign respstream_msg_data   = r_q_data[r_head];

endmodule

// File: tb/tb_proc_mem_responder.sv
// Bench for proc_mem_responder: directed vector table, corner-case sequences and
// randomized traffic checked cycle by cycle against a queue/array reference model.
module tb_proc_mem_responder;
    localparam int NW  = 256;
    localparam int LAT = 1;
    localparam int QD  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reqstream_val = 1'b0;
    logic        reqstream_rdy;
    logic [2:0]  reqstream_msg_type = 3'd0;
    logic [7:0]  reqstream_msg_opaque = 8'd0;
    logic [31:0] reqstream_msg_addr = 32'd0;
    logic [1:0]  reqstream_msg_len = 2'd0;
    logic [31:0] reqstream_msg_data = 32'd0;
    logic        respstream_val;
    logic        respstream_rdy = 1'b1;
    logic [2:0]  respstream_msg_type;
    logic [7:0]  respstream_msg_opaque;
    logic [1:0]  respstream_msg_test;
    logic [1:0]  respstream_msg_len;
    logic [31:0] respstream_msg_data;

    always #5 clk = ~clk;

    proc_mem_responder #(.p_num_words(NW), .p_latency(LAT), .p_qdepth(QD)) dut (
        .clk(clk), .reset(reset),
        .reqstream_val(reqstream_val), .reqstream_rdy(reqstream_rdy),
        .reqstream_msg_type(reqstream_msg_type), .reqstream_msg_opaque(reqstream_msg_opaque),
        .reqstream_msg_addr(reqstream_msg_addr), .reqstream_msg_len(reqstream_msg_len),
        .reqstream_msg_data(reqstream_msg_data),
        .respstream_val(respstream_val), .respstream_rdy(respstream_rdy),
        .respstream_msg_type(respstream_msg_type), .respstream_msg_opaque(respstream_msg_opaque),
        .respstream_msg_test(respstream_msg_test), .respstream_msg_len(respstream_msg_len),
        .respstream_msg_data(respstream_msg_data)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: expected responses in accept order plus a plain word array.
    typedef struct {
        logic [2:0]  typ;
        logic [7:0]  op;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
        int          acc;
    } resp_t;

    resp_t       mq[$];
    logic [31:0] mmem [NW];
    int          cyc = 0;
    bit          fresh = 1'b1;
    int          deq_cyc[$];
    logic [31:0] deq_data[$];

    // Per-cycle monitor, sampled on the falling edge where everything is stable.
    always @(negedge clk) begin
        resp_t r;
        bit    ev;
        int    idx;
        cyc++;
        if (!reset) begin
            mq.delete();
            foreach (mmem[i]) mmem[i] = 32'd0;
            fresh = 1'b1;
        end else begin
            chk("rdy", 32'(reqstream_rdy), 32'(!fresh && (mq.size() < QD)));
            fresh = 1'b0;
            ev = (mq.size() > 0) && (cyc >= mq[0].acc + LAT);
            chk("resp_val", 32'(respstream_val), 32'(ev));
            if (respstream_val && mq.size() > 0) begin
                chk("m_type", 32'(respstream_msg_type), 32'(mq[0].typ));
                chk("m_opaque", 32'(respstream_msg_opaque), 32'(mq[0].op));
                chk("m_test", 32'(respstream_msg_test), 32'(mq[0].test));
                chk("m_len", 32'(respstream_msg_len), 32'(mq[0].len));
                chk("m_data", respstream_msg_data, mq[0].data);
            end
            if (respstream_val && respstream_rdy) begin
                deq_cyc.push_back(cyc);
                deq_data.push_back(respstream_msg_data);
                if (mq.size() > 0) void'(mq.pop_front());
            end
            if (reqstream_val && reqstream_rdy) begin
                r.typ = reqstream_msg_type;
                r.op  = reqstream_msg_opaque;
                r.len = reqstream_msg_len;
                r.acc = cyc;
                r.data = 32'd0;
                if (reqstream_msg_len != 2'd0 || reqstream_msg_type > 3'd2) r.test = 2'd2;
                else if (reqstream_msg_addr >= 32'(4 * NW)) r.test = 2'd1;
                else r.test = 2'd0;
                if (r.test == 2'd0) begin
                    idx = int'(reqstream_msg_addr / 32'd4);
                    if (reqstream_msg_type == 3'd0) r.data = mmem[idx];
                    else mmem[idx] = reqstream_msg_data;
                end
                mq.push_back(r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with respstream_rdy held high; checks its response and latency.
    task automatic send(input string nm, input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                        input logic [1:0] et, input logic [31:0] ed);
        int n;
        reqstream_val = 1'b1;
        reqstream_msg_type = t;
        reqstream_msg_opaque = op;
        reqstream_msg_addr = a;
        reqstream_msg_len = l;
        reqstream_msg_data = d;
        n = 0;
        while (!reqstream_rdy && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_accept"}, 32'(reqstream_rdy), 32'd1);
        tick();
        reqstream_val = 1'b0;
        n = 1;
        while (!respstream_val && n < 20) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(LAT));
        chk({nm, "_type"}, 32'(respstream_msg_type), 32'(t));
        chk({nm, "_opaque"}, 32'(respstream_msg_opaque), 32'(op));
        chk({nm, "_test"}, 32'(respstream_msg_test), 32'(et));
        chk({nm, "_len"}, 32'(respstream_msg_len), 32'(l));
        chk({nm, "_data"}, respstream_msg_data, ed);
        tick();
    endtask

    typedef struct {
        logic [2:0]  t;
        logic [7:0]  op;
        logic [31:0] a;
        logic [1:0]  l;
        logic [31:0] d;
        logic [1:0]  et;
        logic [31:0] ed;
    } vec_t;

    vec_t vt[13];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit fire;
        int n;
        int sel;

        vt[0]  = '{3'd1, 8'h05, 32'h100, 2'd0, 32'hDEADBEEF, 2'd0, 32'h0};
        vt[1]  = '{3'd0, 8'h06, 32'h100, 2'd0, 32'h0,        2'd0, 32'hDEADBEEF};
        vt[2]  = '{3'd0, 8'h07, 32'h400, 2'd0, 32'h0,        2'd1, 32'h0};
        vt[3]  = '{3'd1, 8'h08, 32'h100, 2'd2, 32'h12345678, 2'd2, 32'h0};
        vt[4]  = '{3'd0, 8'h09, 32'h100, 2'd0, 32'h0,        2'd0, 32'hDEADBEEF};
        vt[5]  = '{3'd3, 8'h0A, 32'h100, 2'd0, 32'h0,        2'd2, 32'h0};
        vt[6]  = '{3'd2, 8'h0B, 32'h3FC, 2'd0, 32'hA5A5A5A5, 2'd0, 32'h0};
        vt[7]  = '{3'd0, 8'h0C, 32'h3FF, 2'd0, 32'h0,        2'd0, 32'hA5A5A5A5};
        vt[8]  = '{3'd1, 8'h0D, 32'h404, 2'd0, 32'h11,       2'd1, 32'h0};
        vt[9]  = '{3'd0, 8'h0E, 32'h004, 2'd0, 32'h0,        2'd0, 32'h0};
        vt[10] = '{3'd5, 8'h0F, 32'h800, 2'd1, 32'h0,        2'd2, 32'h0};
        vt[11] = '{3'd4, 8'h10, 32'h100, 2'd0, 32'hFFFFFFFF, 2'd2, 32'h0};
        vt[12] = '{3'd0, 8'h11, 32'h100, 2'd0, 32'h0,        2'd0, 32'hDEADBEEF};

        // Reset state
        #1;
        chk("reset_rdy", 32'(reqstream_rdy), 32'd0);
        chk("reset_val", 32'(respstream_val), 32'd0);
        chk("reset_data", respstream_msg_data, 32'd0);
        chk("reset_opaque", 32'(respstream_msg_opaque), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        chk("rdy_first_cycle", 32'(reqstream_rdy), 32'd0);
        tick();
        chk("rdy_after_reset", 32'(reqstream_rdy), 32'd1);

        // Directed vector table
        respstream_rdy = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send($sformatf("vec%0d", i), vt[i].t, vt[i].op, vt[i].a, vt[i].l, vt[i].d,
                 vt[i].et, vt[i].ed);
        end

        // Back-to-back: 8 init writes then 8 reads, one per cycle
        deq_cyc.delete();
        deq_data.delete();
        for (int i = 0; i < 16; i++) begin
            reqstream_val = 1'b1;
            reqstream_msg_type = (i < 8) ? 3'd2 : 3'd0;
            reqstream_msg_opaque = 8'(8'h40 + i);
            reqstream_msg_addr = 32'((i % 8) * 4);
            reqstream_msg_len = 2'd0;
            reqstream_msg_data = 32'(i % 8);
            chk($sformatf("b2b_rdy%0d", i), 32'(reqstream_rdy), 32'd1);
            tick();
        end
        reqstream_val = 1'b0;
        tick();
        tick();
        tick();
        chk("b2b_count", 32'(deq_data.size()), 32'd16);
        if (deq_data.size() >= 16) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("b2b_data%0d", i), deq_data[8 + i], 32'(i));
                chk($sformatf("b2b_cyc%0d", i), 32'(deq_cyc[8 + i]), 32'(deq_cyc[8] + i));
            end
        end

        // Stall: response side blocked for 5 cycles while requests are offered
        respstream_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            reqstream_val = 1'b1;
            reqstream_msg_type = 3'd0;
            reqstream_msg_opaque = 8'(8'h20 + acc);
            reqstream_msg_addr = 32'(4 * (acc + 1));
            reqstream_msg_len = 2'd0;
            fire = reqstream_rdy;
            tick();
            if (fire) acc++;
        end
        chk("stall_accepts", 32'(acc), 32'(QD));
        chk("stall_rdy", 32'(reqstream_rdy), 32'd0);
        chk("stall_val", 32'(respstream_val), 32'd1);
        chk("stall_head_op", 32'(respstream_msg_opaque), 32'h20);
        chk("stall_head_data", respstream_msg_data, 32'd1);
        respstream_rdy = 1'b1;
        chk("rdy_no_bypass", 32'(reqstream_rdy), 32'd0);
        tick();
        chk("rdy_after_deq", 32'(reqstream_rdy), 32'd1);
        tick();
        reqstream_val = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Reset with requests in flight
        send("rst_w", 3'd1, 8'h30, 32'h40, 2'd0, 32'hCAFEF00D, 2'd0, 32'h0);
        respstream_rdy = 1'b0;
        reqstream_val = 1'b1;
        reqstream_msg_type = 3'd0;
        reqstream_msg_addr = 32'h40;
        reqstream_msg_opaque = 8'h31;
        tick();
        reqstream_msg_opaque = 8'h32;
        tick();
        reqstream_val = 1'b0;
        chk("inflight_val", 32'(respstream_val), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_val", 32'(respstream_val), 32'd0);
        chk("midrst_rdy", 32'(reqstream_rdy), 32'd0);
        chk("midrst_data", respstream_msg_data, 32'd0);
        chk("midrst_type", 32'(respstream_msg_type), 32'd0);
        chk("midrst_opaque", 32'(respstream_msg_opaque), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        respstream_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("no_stale%0d", i), 32'(respstream_val), 32'd0);
        end
        send("rst_rd", 3'd0, 8'h33, 32'h40, 2'd0, 32'h0, 2'd0, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            respstream_rdy = ($urandom_range(0, 3) != 0);
            reqstream_val = ($urandom_range(0, 2) != 0);
            sel = int'($urandom_range(0, 15));
            reqstream_msg_type = (sel == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            reqstream_msg_addr = (sel == 1) ? 32'(32'h400 + $urandom_range(0, 1023) * 4)
                                            : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            reqstream_msg_len = (sel == 2) ? 2'($urandom_range(1, 3)) : 2'd0;
            reqstream_msg_data = $urandom;
            reqstream_msg_opaque = 8'($urandom);
            tick();
        end
        reqstream_val = 1'b0;
        respstream_rdy = 1'b1;
        n = 0;
        while (mq.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain", 32'(mq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
